fetch_decode_ctrl: RTL and testbench
====================================

// Module: fetch_decode_ctrl
// PURPOSE
//  Timing and control front end of the basic 16-bit CPU. A 4-bit sequence counter (SC) is decoded into
//  one-hot timing states T0..T15. The block runs the fetch, decode and indirect-address phases and
//  drives the LD/INR/CLR strobes of the AR, PC and IR register16 instances, plus the common-bus select.
//  From T3 on, it hands off to the execute unit through EXEC_EN, D and I_FLAG.
// PARAMETERS
//  SC_W    4   sequence counter width; T is 2**SC_W one-hot bits
//  AW      12  address field width taken from IR[11:0]
// PORTS
//  CLK       in   1   system clock; all state updates on posedge
//  RST_N     in   1   synchronous active-low reset
//  RUN       in   1   start/stop flip-flop S; 0 freezes SC and zeroes all strobes
//  IR_DATA   in   16  current IR register16 Dataout
//  SC_CLR    in   1   execute unit ends instruction; honoured only when SC>=3
//  T         out  16  one-hot timing state, T[SC]
//  D         out  8   registered one-hot opcode decode of IR[14:12]
//  I_FLAG    out  1   registered indirect bit IR[15]
//  EXEC_EN   out  1   execute phase active (T3 with D[7], or SC>=4), gated by RUN
//  BUS_SEL   out  3   bus source: 0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 MEM
//  MEM_RD    out  1   memory read strobe
//  AR_LD     out  1   AR load
//  AR_INR    out  1   AR increment (held 0 by this block; reserved for execute OR-merge)
//  AR_CLR    out  1   AR clear (held 0; reserved)
//  PC_LD     out  1   PC load (held 0; reserved)
//  PC_INR    out  1   PC increment
//  PC_CLR    out  1   PC clear (held 0; reserved)
//  IR_LD     out  1   IR load
//  SC_WRAP   out  1   one-cycle pulse: SC wrapped 15->0 without SC_CLR (hang detect)
// BEHAVIOUR
//  - Reset (RST_N=0 at posedge): SC=0, D=0, I_FLAG=0, SC_WRAP=0. Then T=16'h0001 and all strobes are 0
//    (RUN=0 after reset in the bench). Reset aborts any instruction in flight.
//  - Strobes, BUS_SEL, MEM_RD and EXEC_EN are combinational from SC, D, I_FLAG and RUN. The register16
//    targets act on the posedge that closes the Tn cycle.
//  - All strobes, BUS_SEL and EXEC_EN are 0 whenever RUN=0.
//  - T0: BUS_SEL=2, AR_LD=1                           (AR <- PC)
//  - T1: BUS_SEL=7, MEM_RD=1, IR_LD=1, PC_INR=1       (IR <- M[AR], PC <- PC+1)
//  - T2: BUS_SEL=5, AR_LD=1                           (AR <- IR[11:0]). At the closing edge:
//        D <= 1<<IR_DATA[14:12], I_FLAG <= IR_DATA[15]. D and I_FLAG are valid from T3.
//  - T3: D[7]=1 -> EXEC_EN=1, no fetch strobes (register-ref or I/O).
//        D[7]=0, I_FLAG=1 -> BUS_SEL=7, MEM_RD=1, AR_LD=1 (AR <- M[AR]).
//        D[7]=0, I_FLAG=0 -> no strobes.
//  - SC>=4: EXEC_EN=1; no strobes from this block.
//  - SC next state, highest priority first: RST_N=0 -> 0; SC_CLR=1 with SC>=3 -> 0 (regardless of RUN, so
//    HLT clears SC while dropping S); RUN=0 -> hold; else SC+1 mod 16.
//  - SC_CLR with SC<3 is ignored.
//  - Wrap: SC=15, RUN=1, SC_CLR=0 -> SC=0, and SC_WRAP=1 for the following cycle.
//  - D and I_FLAG hold their values until the next T2 closing edge.
// STRUCTURE
//  - Shared package cpu_defs_pkg: BUS_SEL codes (BUS_NONE..BUS_MEM), SC_W, opcode field positions
//    (I bit 15, opcode 14:12, addr 11:0), and the T index constants.
//  - Sub-module seq_counter: SC_W-bit counter with CLR (sync), INR and hold, RST_N sync. The strobe
//    decode stays in this block.
// TESTING
//  1 RST_N=0 one cycle, RUN=0 -> T=16'h0001, D=0, I_FLAG=0, every strobe and BUS_SEL=0.
//  2 RUN=1, IR_DATA=16'h2123 from T2 -> T0: BUS_SEL=2 AR_LD; T1: BUS_SEL=7 MEM_RD IR_LD PC_INR;
//    T2: BUS_SEL=5 AR_LD; T3: D=8'h04 I_FLAG=0, no strobes; T4: EXEC_EN=1.
//  3 IR_DATA=16'hA123 -> T3: I_FLAG=1, BUS_SEL=7 MEM_RD=1 AR_LD=1; SC_CLR at T5 -> T=16'h0001 next cycle.
//  4 IR_DATA=16'h7800 -> T3: D=8'h80 EXEC_EN=1; SC_CLR at T3 -> next cycle T0 with BUS_SEL=2 AR_LD.
//  5 RUN=0 during T1 for 3 cycles -> T stays 16'h0002, strobes 0; RUN=1 -> T1 strobes reappear, then T2.
//  6 SC_CLR pulsed at T1 -> ignored, T2 follows; no SC_CLR through T15 -> T0, SC_WRAP=1 for one cycle;
//    RST_N=0 at T2 -> T=16'h0001, D unchanged from previous value=0 after reset.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the 16-bit CPU front end: bus source codes, instruction
// field positions and timing-state indices.
package cpu_defs_pkg;

    localparam int SC_W = 4;
    localparam int T_N  = 1 << SC_W;
    localparam int AW   = 12;

    localparam int I_BIT   = 15;
    localparam int OP_HI   = 14;
    localparam int OP_LO   = 12;
    localparam int ADDR_HI = AW - 1;
    localparam int ADDR_LO = 0;

    localparam logic [SC_W-1:0] T0_IDX = SC_W'(0);
    localparam logic [SC_W-1:0] T1_IDX = SC_W'(1);
    localparam logic [SC_W-1:0] T2_IDX = SC_W'(2);
    localparam logic [SC_W-1:0] T3_IDX = SC_W'(3);

    typedef enum logic [2:0] {
        BUS_NONE = 3'd0,
        BUS_AR   = 3'd1,
        BUS_PC   = 3'd2,
        BUS_DR   = 3'd3,
        BUS_AC   = 3'd4,
        BUS_IR   = 3'd5,
        BUS_TR   = 3'd6,
        BUS_MEM  = 3'd7
    } bus_sel_t;

endpackage

// File: rtl/fetch_decode_ctrl_if.sv
// Control bundle between the fetch/decode front end (master) and the datapath/execute side.
interface fetch_decode_ctrl_if;
    import cpu_defs_pkg::*;

    logic                 run;
    logic [15:0]          ir_data;
    logic                 sc_clr;
    logic [T_N-1:0]       t;
    logic [7:0]           d;
    logic                 i_flag;
    logic                 exec_en;
    bus_sel_t             bus_sel;
    logic                 mem_rd;
    logic                 ar_ld;
    logic                 ar_inr;
    logic                 ar_clr;
    logic                 pc_ld;
    logic                 pc_inr;
    logic                 pc_clr;
    logic                 ir_ld;
    logic                 sc_wrap;

    modport master (
        input  run, ir_data, sc_clr,
        output t, d, i_flag, exec_en, bus_sel, mem_rd,
               ar_ld, ar_inr, ar_clr, pc_ld, pc_inr, pc_clr, ir_ld, sc_wrap
    );

    modport slave (
        output run, ir_data, sc_clr,
        input  t, d, i_flag, exec_en, bus_sel, mem_rd,
               ar_ld, ar_inr, ar_clr, pc_ld, pc_inr, pc_clr, ir_ld, sc_wrap
    );

endinterface

// File: rtl/seq_counter.sv
// Sequence counter with synchronous clear, increment and hold; flags a natural
// wrap from all-ones to zero one cycle after it happens.
module seq_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inr,
    output logic [W-1:0] count,
    output logic         wrap
);

    logic [W-1:0] count_reg;
    logic         wrap_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
            wrap_reg  <= 1'b0;
        end else begin
            wrap_reg <= inr && !clr && (count_reg == '1);
            if (clr) begin
                count_reg <= '0;
            end else if (inr) begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    assign count = count_reg;
    assign wrap  = wrap_reg;

endmodule

// File: rtl/fetch_decode_ctrl.sv
// Timing and control front end: T-state decode, fetch/decode/indirect strobes and
// the hand-off to the execute unit.
module fetch_decode_ctrl
    import cpu_defs_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    fetch_decode_ctrl_if.master  bus
);

    logic [SC_W-1:0] sc;
    logic            sc_clr_ok;
    logic            sc_wrap;
    logic [T_N-1:0]  t_vec;
    logic [7:0]      d_reg;
    logic            i_flag_reg;

    // Early clears would abort the fetch itself, so they only count from T3 on.
    assign sc_clr_ok = bus.sc_clr && (sc >= T3_IDX);

    seq_counter #(.W(SC_W)) u_sc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (sc_clr_ok),
        .inr   (bus.run),
        .count (sc),
        .wrap  (sc_wrap)
    );

    for (genvar gi = 0; gi < T_N; gi++) begin : g_t
        assign t_vec[gi] = (sc == SC_W'(gi));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_reg      <= 8'h00;
            i_flag_reg <= 1'b0;
        end else if (bus.run && (sc == T2_IDX)) begin
            d_reg      <= 8'h01 << bus.ir_data[OP_HI:OP_LO];
            i_flag_reg <= bus.ir_data[I_BIT];
        end
    end

    bus_sel_t bus_sel;
    logic     mem_rd;
    logic     ar_ld;
    logic     pc_inr;
    logic     ir_ld;
    logic     exec_en;

    always_comb begin
        bus_sel = BUS_NONE;
        mem_rd  = 1'b0;
        ar_ld   = 1'b0;
        pc_inr  = 1'b0;
        ir_ld   = 1'b0;
        exec_en = 1'b0;
        if (bus.run) begin
            case (sc)
                T0_IDX: begin
                    bus_sel = BUS_PC;
                    ar_ld   = 1'b1;
                end
                T1_IDX: begin
                    bus_sel = BUS_MEM;
                    mem_rd  = 1'b1;
                    ir_ld   = 1'b1;
                    pc_inr  = 1'b1;
                end
                T2_IDX: begin
                    bus_sel = BUS_IR;
                    ar_ld   = 1'b1;
                end
                T3_IDX: begin
                    // Register-reference/I-O go straight to execute; memory-ref may need an indirect hop.
                    if (d_reg[7]) begin
                        exec_en = 1'b1;
                    end else if (i_flag_reg) begin
                        bus_sel = BUS_MEM;
                        mem_rd  = 1'b1;
                        ar_ld   = 1'b1;
                    end
                end
                default: exec_en = 1'b1;
            endcase
        end
    end

    assign bus.t       = t_vec;
    assign bus.d       = d_reg;
    assign bus.i_flag  = i_flag_reg;
    assign bus.exec_en = exec_en;
    assign bus.bus_sel = bus_sel;
    assign bus.mem_rd  = mem_rd;
    assign bus.ar_ld   = ar_ld;
    assign bus.ar_inr  = 1'b0;
    assign bus.ar_clr  = 1'b0;
    assign bus.pc_ld   = 1'b0;
    assign bus.pc_inr  = pc_inr;
    assign bus.pc_clr  = 1'b0;
    assign bus.ir_ld   = ir_ld;
    assign bus.sc_wrap = sc_wrap;

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Self-checking bench for fetch_decode_ctrl: directed scenarios followed by random
// stimulus, all checked against a behavioural model of the timing rules.
module tb_fetch_decode_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_decode_ctrl_if bus ();

    fetch_decode_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state
    int         m_sc;
    logic [7:0] m_d;
    logic       m_i;
    logic       m_wrap;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [2:0] e_bus;
        logic e_mem, e_arld, e_pcinr, e_irld, e_exec;
        e_bus = 3'd0; e_mem = 0; e_arld = 0; e_pcinr = 0; e_irld = 0; e_exec = 0;
        if (bus.run) begin
            if (m_sc == 0) begin
                e_bus = 3'd2; e_arld = 1;
            end else if (m_sc == 1) begin
                e_bus = 3'd7; e_mem = 1; e_irld = 1; e_pcinr = 1;
            end else if (m_sc == 2) begin
                e_bus = 3'd5; e_arld = 1;
            end else if (m_sc == 3) begin
                if (m_d[7]) e_exec = 1;
                else if (m_i) begin e_bus = 3'd7; e_mem = 1; e_arld = 1; end
            end else begin
                e_exec = 1;
            end
        end
        chk($sformatf("%s.t", tag),       32'(bus.t),       32'(1) << m_sc);
        chk($sformatf("%s.d", tag),       32'(bus.d),       32'(m_d));
        chk($sformatf("%s.i_flag", tag),  32'(bus.i_flag),  32'(m_i));
        chk($sformatf("%s.exec_en", tag), 32'(bus.exec_en), 32'(e_exec));
        chk($sformatf("%s.bus_sel", tag), 32'(bus.bus_sel), 32'(e_bus));
        chk($sformatf("%s.mem_rd", tag),  32'(bus.mem_rd),  32'(e_mem));
        chk($sformatf("%s.ar_ld", tag),   32'(bus.ar_ld),   32'(e_arld));
        chk($sformatf("%s.pc_inr", tag),  32'(bus.pc_inr),  32'(e_pcinr));
        chk($sformatf("%s.ir_ld", tag),   32'(bus.ir_ld),   32'(e_irld));
        chk($sformatf("%s.sc_wrap", tag), 32'(bus.sc_wrap), 32'(m_wrap));
        chk($sformatf("%s.reserved", tag),
            32'({bus.ar_inr, bus.ar_clr, bus.pc_ld, bus.pc_clr}), 32'(0));
    endtask

    // One clock: drive inputs, check mid-cycle, then advance the model on the edge.
    task automatic cyc(input string tag, input logic r, input logic [15:0] ir,
                       input logic clr, input logic rn);
        logic w;
        bus.run     = r;
        bus.ir_data = ir;
        bus.sc_clr  = clr;
        rst_n       = rn;
        @(negedge clk);
        check_all(tag);
        @(posedge clk);
        if (!rn) begin
            m_sc = 0; m_d = 8'h00; m_i = 1'b0; m_wrap = 1'b0;
        end else begin
            w = (m_sc == 15) && r && !clr;
            if (r && m_sc == 2) begin
                m_d = 8'h01 << ir[14:12];
                m_i = ir[15];
            end
            if (clr && m_sc >= 3) m_sc = 0;
            else if (r)           m_sc = (m_sc + 1) % 16;
            m_wrap = w;
        end
        #1;
    endtask

    initial begin
        logic       r, c, rn;
        logic [15:0] ir;

        bus.run = 1'b0; bus.ir_data = 16'h0000; bus.sc_clr = 1'b0; rst_n = 1'b0;
        @(posedge clk);
        m_sc = 0; m_d = 8'h00; m_i = 1'b0; m_wrap = 1'b0;
        #1;

        // 1: reset state with RUN low
        cyc("rst_idle", 0, 16'h0000, 0, 1);
        chk("rst_t", 32'(bus.t), 32'h0001);
        chk("rst_d", 32'(bus.d), 32'h00);
        chk("rst_bus_sel", 32'(bus.bus_sel), 32'd0);

        // 2: direct memory-reference fetch
        cyc("f2_t0", 1, 16'h2123, 0, 1);
        cyc("f2_t1", 1, 16'h2123, 0, 1);
        cyc("f2_t2", 1, 16'h2123, 0, 1);
        chk("f2_d", 32'(bus.d), 32'h04);
        chk("f2_i", 32'(bus.i_flag), 32'd0);
        cyc("f2_t3", 1, 16'h2123, 0, 1);
        cyc("f2_t4", 1, 16'h2123, 0, 1);
        chk("f2_exec_t5", 32'(bus.exec_en), 32'd1);
        cyc("f2_t5clr", 1, 16'h2123, 1, 1);

        // 3: indirect fetch, cleared at T5
        cyc("f3_t0", 1, 16'hA123, 0, 1);
        cyc("f3_t1", 1, 16'hA123, 0, 1);
        cyc("f3_t2", 1, 16'hA123, 0, 1);
        chk("f3_i", 32'(bus.i_flag), 32'd1);
        chk("f3_bus_sel", 32'(bus.bus_sel), 32'd7);
        cyc("f3_t3", 1, 16'hA123, 0, 1);
        cyc("f3_t4", 1, 16'hA123, 0, 1);
        cyc("f3_t5clr", 1, 16'hA123, 1, 1);
        chk("f3_t_after_clr", 32'(bus.t), 32'h0001);

        // 4: register-reference, cleared at T3
        cyc("f4_t0", 1, 16'h7800, 0, 1);
        cyc("f4_t1", 1, 16'h7800, 0, 1);
        cyc("f4_t2", 1, 16'h7800, 0, 1);
        chk("f4_d", 32'(bus.d), 32'h80);
        chk("f4_exec", 32'(bus.exec_en), 32'd1);
        cyc("f4_t3clr", 1, 16'h7800, 1, 1);
        chk("f4_t0_t", 32'(bus.t), 32'h0001);
        chk("f4_t0_bus", 32'(bus.bus_sel), 32'd2);
        chk("f4_t0_arld", 32'(bus.ar_ld), 32'd1);

        // 5: RUN dropped during T1
        cyc("f5_t0", 1, 16'h1000, 0, 1);
        for (int k = 0; k < 3; k++) cyc("f5_hold", 0, 16'h1000, 0, 1);
        chk("f5_hold_t", 32'(bus.t), 32'h0002);
        chk("f5_hold_irld", 32'(bus.ir_ld), 32'd0);
        cyc("f5_t1", 1, 16'h1000, 0, 1);
        chk("f5_t2_t", 32'(bus.t), 32'h0004);

        // 6: run out to T15 and wrap, early clear ignored, reset mid-fetch
        for (int k = 2; k < 16; k++) cyc("f6_run", 1, 16'h1000, 0, 1);
        chk("f6_wrap", 32'(bus.sc_wrap), 32'd1);
        chk("f6_wrap_t", 32'(bus.t), 32'h0001);
        cyc("f6_t0", 1, 16'h1000, 0, 1);
        chk("f6_wrap_gone", 32'(bus.sc_wrap), 32'd0);
        cyc("f6_t1clr", 1, 16'h1000, 1, 1);
        chk("f6_clr_ignored", 32'(bus.t), 32'h0004);
        cyc("f6_t2rst", 1, 16'h1000, 0, 0);
        chk("f6_rst_t", 32'(bus.t), 32'h0001);
        chk("f6_rst_d", 32'(bus.d), 32'h00);

        // Random traffic: frequent clears first, then long runs that reach the wrap.
        for (int k = 0; k < 400; k++) begin
            r  = ($urandom_range(0, 7) != 0);
            ir = 16'($urandom);
            c  = ($urandom_range(0, 4) == 0);
            rn = ($urandom_range(0, 50) != 0);
            cyc("rnd_a", r, ir, c, rn);
        end
        for (int k = 0; k < 400; k++) begin
            r  = ($urandom_range(0, 15) != 0);
            ir = 16'($urandom);
            c  = ($urandom_range(0, 39) == 0);
            rn = ($urandom_range(0, 150) != 0);
            cyc("rnd_b", r, ir, c, rn);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
